// File: rtl/conv_pe_sync.sv
// Clocked convolution PE: loads a filter, slides it over a spike row one MAC per clock,
// emits saturated psums to a rotating set of adders, then optionally forwards the row.
module conv_pe_sync #(
  parameter int                         PACKET_W  = 64,
  parameter int                         ADDR_W    = 4,
  parameter int                         IFMAP_LEN = 25,
  parameter int                         TAPS      = 5,
  parameter int                         WEIGHT_W  = 8,
  parameter int                         PSUM_W    = 13,
  parameter int                         NUM_DEST  = 7,
  parameter logic [NUM_DEST*ADDR_W-1:0] DEST_TABLE = 28'hD9EFB62,
  parameter logic [ADDR_W-1:0]          PE_ADDR   = 4'h0,
  parameter bit                         FWD_EN    = 1'b1,
  parameter logic [ADDR_W-1:0]          FWD_ADDR  = 4'h1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PACKET_W-1:0] in_packet,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PACKET_W-1:0] out_packet,
  output logic                drop_err
);
  localparam int OUT_COUNT = IFMAP_LEN - TAPS + 1;
  localparam int PAY_W     = PACKET_W - 2*ADDR_W - 2;
  localparam int WIN_W     = $clog2(OUT_COUNT);
  localparam int TAP_W     = $clog2(TAPS);
  localparam int IDX_W     = $clog2(IFMAP_LEN);
  localparam int DI_W      = $clog2(NUM_DEST + 1);
  localparam int SUM_W     = PSUM_W + WEIGHT_W;
  localparam logic [PSUM_W-1:0] PSUM_MAX = '1;

  typedef enum logic [1:0] {IDLE, MAC, EMIT, FWD} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] src;
    logic [1:0]        typ;
    logic [PAY_W-1:0]  payload;
  } pkt_t;

  state_t                           state_q, state_d;
  logic [TAPS-1:0][WEIGHT_W-1:0]    w_q, w_d;
  logic                             filt_loaded_q, filt_loaded_d;
  logic [IFMAP_LEN-1:0]             row_q, row_d;
  logic [WIN_W-1:0]                 win_q, win_d;
  logic [TAP_W-1:0]                 tap_q, tap_d;
  logic [PSUM_W-1:0]                acc_q, acc_d;
  logic [DI_W-1:0]                  dest_idx_q, dest_idx_d;
  logic                             drop_err_q, drop_err_d;

  pkt_t                             in_pkt, out_pkt;
  logic [IDX_W-1:0]                 idx;
  logic [SUM_W-1:0]                 sum;
  logic                             unused_in;

  assign in_pkt    = pkt_t'(in_packet);
  assign unused_in = ^{in_pkt.dst, in_pkt.src, in_pkt.payload[PAY_W-1:TAPS*WEIGHT_W]};
  assign idx       = IDX_W'(win_q) + IDX_W'(tap_q);
  assign sum       = SUM_W'(acc_q) + SUM_W'(row_q[idx] ? w_q[tap_q] : '0);

  always_comb begin
    state_d       = state_q;
    w_d           = w_q;
    filt_loaded_d = filt_loaded_q;
    row_d         = row_q;
    win_d         = win_q;
    tap_d         = tap_q;
    acc_d         = acc_q;
    dest_idx_d    = dest_idx_q;
    drop_err_d    = drop_err_q;
    in_ready      = (state_q == IDLE);
    out_valid     = 1'b0;
    out_pkt       = '0;
    case (state_q)
      IDLE: if (in_valid) begin
        case (in_pkt.typ)
          2'b01: begin
            w_d           = in_pkt.payload[TAPS*WEIGHT_W-1:0];
            filt_loaded_d = 1'b1;
          end
          2'b00: if (filt_loaded_q) begin
            row_d   = in_pkt.payload[IFMAP_LEN-1:0];
            win_d   = '0;
            tap_d   = '0;
            acc_d   = '0;
            state_d = MAC;
          end else begin
            drop_err_d = 1'b1;
          end
          default: drop_err_d = 1'b1;
        endcase
      end
      MAC: begin
        // Clamp rather than wrap: a saturated psum still reads as "very active".
        acc_d = (sum > SUM_W'(PSUM_MAX)) ? PSUM_MAX : sum[PSUM_W-1:0];
        if (tap_q == TAP_W'(TAPS-1)) state_d = EMIT;
        else                         tap_d   = tap_q + 1'b1;
      end
      EMIT: begin
        out_valid   = 1'b1;
        out_pkt.dst = DEST_TABLE[dest_idx_q*ADDR_W +: ADDR_W];
        out_pkt.src = PE_ADDR;
        out_pkt.typ = 2'b10;
        out_pkt.payload = PAY_W'(acc_q);
        if (out_ready) begin
          dest_idx_d = (dest_idx_q == DI_W'(NUM_DEST-1)) ? '0 : dest_idx_q + 1'b1;
          if (win_q < WIN_W'(OUT_COUNT-1)) begin
            win_d   = win_q + 1'b1;
            tap_d   = '0;
            acc_d   = '0;
            state_d = MAC;
          end else begin
            state_d = FWD_EN ? FWD : IDLE;
          end
        end
      end
      FWD: begin
        out_valid   = 1'b1;
        out_pkt.dst = FWD_ADDR;
        out_pkt.src = PE_ADDR;
        out_pkt.typ = 2'b00;
        out_pkt.payload = PAY_W'(row_q);
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_packet = out_pkt;
  assign drop_err   = drop_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      w_q           <= '0;
      filt_loaded_q <= 1'b0;
      row_q         <= '0;
      win_q         <= '0;
      tap_q         <= '0;
      acc_q         <= '0;
      dest_idx_q    <= '0;
      drop_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      w_q           <= w_d;
      filt_loaded_q <= filt_loaded_d;
      row_q         <= row_d;
      win_q         <= win_d;
      tap_q         <= tap_d;
      acc_q         <= acc_d;
      dest_idx_q    <= dest_idx_d;
      drop_err_q    <= drop_err_d;
    end
  end
endmodule
